// File: rtl/park_pay_station.sv
// Exit-side pay station: bills parked time, collects coins, pulses pay with change or refunds on cancel.
// Fee is computed one billed unit per cycle in CALC; every output is registered.
module park_pay_station #(
    parameter int TW             = 16,
    parameter int TICKS_PER_UNIT = 60,
    parameter int RATE           = 2,
    parameter int CW             = 8,
    parameter int FEE_MAX        = 240
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [TW-1:0] now,
    input  logic          req,
    input  logic [TW-1:0] t_entry,
    input  logic          coin,
    input  logic [3:0]    coin_val,
    input  logic          cancel,
    output logic          busy,
    output logic [CW-1:0] cost,
    output logic          pay,
    output logic [CW-1:0] change,
    output logic          change_valid
);
    typedef enum logic [1:0] {IDLE, CALC, COLLECT, DONE} state_t;

    localparam logic [TW-1:0] TPU_W     = TW'(TICKS_PER_UNIT);
    localparam logic [CW:0]   RATE_W    = (CW+1)'(RATE);
    localparam logic [CW:0]   FEE_MAX_W = (CW+1)'(FEE_MAX);

    state_t        state, state_nx;
    logic [TW-1:0] elapsed, elapsed_nx;
    logic [CW-1:0] fee, fee_nx;
    logic [CW:0]   inserted, inserted_nx;
    logic [CW:0]   fee_sum, ins_sum;
    logic [CW-1:0] cost_nx, change_nx;
    logic          busy_nx, pay_nx, change_valid_nx;

    always_comb begin
        state_nx        = state;
        elapsed_nx      = elapsed;
        fee_nx          = fee;
        inserted_nx     = inserted;
        change_nx       = '0;
        pay_nx          = 1'b0;
        change_valid_nx = 1'b0;
        fee_sum         = {1'b0, fee} + RATE_W;
        ins_sum         = inserted + (coin ? (CW+1)'(coin_val) : '0);

        case (state)
            IDLE: begin
                if (req) begin
                    elapsed_nx  = now - t_entry;
                    fee_nx      = '0;
                    inserted_nx = '0;
                    state_nx    = CALC;
                end
            end
            CALC: begin
                if (cancel) begin
                    state_nx = IDLE;
                end else if (fee_sum >= FEE_MAX_W) begin
                    fee_nx   = CW'(FEE_MAX);
                    state_nx = COLLECT;
                end else begin
                    fee_nx = fee_sum[CW-1:0];
                    if (elapsed > TPU_W)
                        elapsed_nx = elapsed - TPU_W;
                    else
                        state_nx = COLLECT;
                end
            end
            COLLECT: begin
                inserted_nx = ins_sum;
                // A same-cycle coin is counted first, so the refund includes it.
                if (cancel) begin
                    change_nx       = ins_sum[CW-1:0];
                    change_valid_nx = 1'b1;
                    state_nx        = IDLE;
                end else if (ins_sum >= {1'b0, fee}) begin
                    change_nx       = CW'(ins_sum - {1'b0, fee});
                    change_valid_nx = 1'b1;
                    pay_nx          = 1'b1;
                    state_nx        = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx != IDLE);
        case (state_nx)
            CALC:    cost_nx = fee_nx;
            COLLECT: cost_nx = fee_nx - inserted_nx[CW-1:0];
            default: cost_nx = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            elapsed      <= '0;
            fee          <= '0;
            inserted     <= '0;
            busy         <= 1'b0;
            cost         <= '0;
            pay          <= 1'b0;
            change       <= '0;
            change_valid <= 1'b0;
        end else begin
            state        <= state_nx;
            elapsed      <= elapsed_nx;
            fee          <= fee_nx;
            inserted     <= inserted_nx;
            busy         <= busy_nx;
            cost         <= cost_nx;
            pay          <= pay_nx;
            change       <= change_nx;
            change_valid <= change_valid_nx;
        end
    end
endmodule

// File: tb/tb_park_pay_station.sv
// Self-checking bench for park_pay_station: directed plan scenarios plus randomized transactions vs a fee-formula model.
module tb_park_pay_station;
    localparam int TW = 16, TPU = 60, RATE = 2, CW = 8, FEE_MAX = 240;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [TW-1:0] now = '0;
    logic          req = 1'b0;
    logic [TW-1:0] t_entry = '0;
    logic          coin = 1'b0;
    logic [3:0]    coin_val = '0;
    logic          cancel = 1'b0;
    logic          busy, pay, change_valid;
    logic [CW-1:0] cost, change;

    int errors = 0;
    int checks = 0;
    int m_fee = 0;
    int m_ins = 0;

    park_pay_station #(.TW(TW), .TICKS_PER_UNIT(TPU), .RATE(RATE), .CW(CW), .FEE_MAX(FEE_MAX)) dut (
        .clk(clk), .rst(rst), .now(now), .req(req), .t_entry(t_entry),
        .coin(coin), .coin_val(coin_val), .cancel(cancel),
        .busy(busy), .cost(cost), .pay(pay), .change(change), .change_valid(change_valid)
    );

    always #5 clk = ~clk;

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int units_of(input int el);
        return (el == 0) ? 1 : (el + TPU - 1) / TPU;
    endfunction

    function automatic int fee_of(input int el);
        return min_i(FEE_MAX, RATE * units_of(el));
    endfunction

    function automatic int calc_cycles(input int el);
        return min_i(units_of(el), (FEE_MAX + RATE - 1) / RATE);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        req = 1'b0;
        coin = 1'b0;
        cancel = 1'b0;
    endtask

    // Launch a request and follow the CALC phase cycle by cycle against the running-fee formula.
    task automatic start_txn(input int te, input int nw, input string tag);
        int el, cyc;
        el = (nw - te) & ((1 << TW) - 1);
        cyc = calc_cycles(el);
        t_entry = TW'(te);
        now = TW'(nw);
        req = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1 || cost !== 0) begin
            errors++;
            $display("FAIL %s_calc_start busy=%0b cost=%0d expected busy=1 cost=0", tag, busy, cost);
        end
        for (int k = 1; k <= cyc; k++) begin
            tick();
            checks++;
            if (cost !== CW'(min_i(FEE_MAX, RATE * k)) || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s_calc_cycle%0d cost=%0d busy=%0b expected cost=%0d busy=1",
                         tag, k, cost, busy, min_i(FEE_MAX, RATE * k));
            end
        end
        m_fee = fee_of(el);
        m_ins = 0;
    endtask

    // One coin in COLLECT; optional stray req must be ignored.
    task automatic insert_coin(input int val, input bit with_req, input string tag);
        coin = 1'b1;
        coin_val = 4'(val);
        req = with_req;
        t_entry = TW'($urandom);
        tick();
        m_ins += val;
        if (m_ins >= m_fee) begin
            checks++;
            if (pay !== 1'b1 || change_valid !== 1'b1 || change !== CW'(m_ins - m_fee) ||
                cost !== 0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s_paid pay=%0b cv=%0b change=%0d cost=%0d busy=%0b expected 1 1 %0d 0 1",
                         tag, pay, change_valid, change, cost, busy, m_ins - m_fee);
            end
            tick();
            checks++;
            if (busy !== 1'b0 || pay !== 1'b0 || change_valid !== 1'b0 || cost !== 0 || change !== 0) begin
                errors++;
                $display("FAIL %s_after_done busy=%0b pay=%0b cv=%0b cost=%0d change=%0d expected all 0",
                         tag, busy, pay, change_valid, cost, change);
            end
        end else begin
            checks++;
            if (cost !== CW'(m_fee - m_ins) || pay !== 1'b0 || change_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s_partial cost=%0d pay=%0b cv=%0b busy=%0b expected cost=%0d 0 0 1",
                         tag, cost, pay, change_valid, busy, m_fee - m_ins);
            end
        end
    endtask

    task automatic do_cancel(input bit with_coin, input int val, input string tag);
        cancel = 1'b1;
        coin = with_coin;
        coin_val = 4'(val);
        tick();
        if (with_coin) m_ins += val;
        checks++;
        if (change_valid !== 1'b1 || change !== CW'(m_ins) || pay !== 1'b0 || busy !== 1'b0 || cost !== 0) begin
            errors++;
            $display("FAIL %s_refund cv=%0b change=%0d pay=%0b busy=%0b cost=%0d expected 1 %0d 0 0 0",
                     tag, change_valid, change, pay, busy, cost, m_ins);
        end
        tick();
        checks++;
        if (change_valid !== 1'b0 || change !== 0) begin
            errors++;
            $display("FAIL %s_refund_one_cycle cv=%0b change=%0d expected 0 0", tag, change_valid, change);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 0 || cost !== 0 || pay !== 0 || change !== 0 || change_valid !== 0) begin
            errors++;
            $display("FAIL reset busy=%0b cost=%0d pay=%0b change=%0d cv=%0b expected all 0",
                     busy, cost, pay, change, change_valid);
        end
        rst = 1'b0;
        coin = 1'b1; coin_val = 4'd9; cancel = 1'b1;
        tick();
        checks++;
        if (busy !== 0 || change_valid !== 0 || cost !== 0) begin
            errors++;
            $display("FAIL idle_ignores_coin busy=%0b cv=%0b cost=%0d expected 0 0 0", busy, change_valid, cost);
        end
    endtask

    task automatic test_normal();
        start_txn(100, 250, "normal");
        insert_coin(5, 1'b0, "normal_c1");
        insert_coin(5, 1'b0, "normal_c2");
    endtask

    task automatic test_min_charge();
        start_txn(500, 500, "minchg");
        insert_coin(2, 1'b0, "minchg_c1");
    endtask

    task automatic test_wrap();
        start_txn(65530, 50, "wrap");
        insert_coin(1, 1'b0, "wrap_c1");
        insert_coin(3, 1'b0, "wrap_c2");
    endtask

    task automatic test_fee_cap();
        start_txn(0, 60000, "cap");
        for (int i = 0; i < 16; i++) insert_coin(15, 1'b0, "cap_coin");
    endtask

    task automatic test_cancel();
        start_txn(100, 250, "cancel");
        insert_coin(3, 1'b1, "cancel_c1");
        do_cancel(1'b1, 4, "cancel");
    endtask

    task automatic test_reset_mid();
        start_txn(100, 250, "rstmid");
        insert_coin(3, 1'b0, "rstmid_c1");
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 0 || cost !== 0 || pay !== 0 || change !== 0 || change_valid !== 0) begin
            errors++;
            $display("FAIL reset_mid busy=%0b cost=%0d pay=%0b change=%0d cv=%0b expected all 0",
                     busy, cost, pay, change, change_valid);
        end
        rst = 1'b0;
        start_txn(100, 250, "rstmid_fresh");
        insert_coin(5, 1'b0, "rstmid_fresh_c1");
        insert_coin(1, 1'b0, "rstmid_fresh_c2");
    endtask

    task automatic test_random();
        int te, el, guard;
        for (int n = 0; n < 40; n++) begin
            te = int'($urandom_range(0, 65535));
            el = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 900));
            start_txn(te, (te + el) & 16'hFFFF, "rnd");
            guard = 0;
            while (m_ins < m_fee && guard < 300) begin
                guard++;
                if ($urandom_range(0, 19) == 0) begin
                    do_cancel(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), "rnd_cancel");
                    break;
                end
                insert_coin(int'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0), "rnd_coin");
            end
            if (guard >= 300) begin
                errors++;
                $display("FAIL rnd_budget inserted=%0d fee=%0d not settled within budget", m_ins, m_fee);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_min_charge();
        test_wrap();
        test_fee_cap();
        test_cancel();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/park_pay_station.md
Name: park_pay_station

Overview:
- Payment terminal at the exit side of the car park controller, producing the `pay` input that the controller consumes.
- On an exit request it computes the parking fee from the ticket's entry timestamp and the global time counter.
- It accepts coins until the fee is covered, then issues a one-cycle `pay` pulse together with the change due.
- A cancel request refunds every coin inserted so far.

Parameters:
- TW, 16, width of timestamps (`now`, `t_entry`); elapsed time is computed modulo 2^TW.
- TICKS_PER_UNIT, 60, clock ticks per billed time unit; must be ≥ 1.
- RATE, 2, coin credits charged per billed unit.
- CW, 8, width of the cost and change outputs.
- FEE_MAX, 240, fee cap in credits; must satisfy FEE_MAX ≤ 2^CW − 16.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- now  input  TW  global time counter from the car park controller.
- req  input  1  one-cycle exit request; `t_entry` is valid in the same cycle.
- t_entry  input  TW  entry timestamp read from the ticket.
- coin  input  1  one-cycle coin-inserted strobe.
- coin_val  input  4  value of the inserted coin in credits, 1..15; a value of 0 is accepted but adds nothing.
- cancel  input  1  one-cycle abort and refund request.
- busy  output  1  high in every state except IDLE.
- cost  output  CW  credits still due; 0 in IDLE.
- pay  output  1  one-cycle pulse: fee fully paid, controller may open the exit bar.
- change  output  CW  change or refund amount; non-zero only while `change_valid` is high.
- change_valid  output  1  one-cycle strobe qualifying `change`.

Behaviour:
- Reset (rst=1 at a clock edge, any state including mid-transaction):
  - state → IDLE.
  - `busy`, `cost`, `pay`, `change`, `change_valid` → 0.
  - All internal accumulators → 0.
- States: IDLE, CALC, COLLECT, DONE. All outputs are registered.
- IDLE:
  - On `req`=1: latch elapsed = (now − t_entry) mod 2^TW, clear fee and inserted, go to CALC.
  - `coin` and `cancel` are ignored.
- CALC, one iteration per cycle:
  - Each cycle adds RATE to fee, saturating at FEE_MAX.
  - If elapsed > TICKS_PER_UNIT: subtract TICKS_PER_UNIT from elapsed and stay in CALC.
  - Otherwise go to COLLECT.
  - Exit CALC immediately when fee reaches FEE_MAX.
  - Result: fee = min(FEE_MAX, RATE × max(1, ceil(elapsed/TICKS_PER_UNIT))). Elapsed = 0 bills one unit.
  - Latency from `req` to COLLECT entry = number of billed units cycles, counting units only until the cap is reached.
  - `cost` shows the running fee; `coin` is ignored; `cancel` returns to IDLE with no refund strobe.
- COLLECT:
  - `cost` = fee − inserted.
  - On `coin`: inserted += coin_val, using a CW+1-bit accumulator.
  - If the new inserted ≥ fee: go to DONE, with change = inserted − fee.
  - On `cancel`, including when `coin` is high in the same cycle:
    - The coin is counted, then refunded.
    - change = inserted + coin_val, `change_valid`=1 for one cycle.
    - `pay` stays 0; return to IDLE.
    - Cancel has priority over payment completion.
- DONE, exactly one cycle:
  - `pay`=1, `change_valid`=1, `change` = overpayment (0 if exact), `cost`=0.
  - Next state is IDLE.
- `req` in any state other than IDLE is ignored; the transaction in progress continues unaffected.
- At most one `pay` pulse per accepted `req`; `pay` and a refund strobe never occur for the same transaction.
- Width rule: inserted never exceeds FEE_MAX+14, so `change` always fits in CW bits.

Test Plan:
1. Normal payment: t_entry=100, now=250 → elapsed 150, 3 units.
   - `cost` settles at 6 after 3 CALC cycles.
   - coin 5 → `cost` 1; coin 5 → `pay` pulse with `change`=4, `change_valid`=1; next cycle IDLE, `busy`=0.
2. Minimum charge: t_entry=now=500 → `cost`=2.
   - coin 2 → `pay`=1 with `change`=0 and `change_valid`=1.
3. Wrap-around: TW=16, t_entry=65530, now=50 → elapsed 56 → 1 unit, `cost`=2.
4. Fee cap: t_entry=0, now=60000 → `cost`=240, reached after 120 CALC cycles, not 1000.
   - 16 coins of 15 → `pay` with `change`=0.
5. Cancel with simultaneous coin: fee 6, coin 3 inserted, then `cancel`+`coin`(4) in the same cycle.
   - `change`=7, `change_valid`=1, `pay`=0, back to IDLE.
   - A `req` during COLLECT is ignored.
6. Reset during COLLECT with 3 credits inserted: all outputs 0, state IDLE.
   - A following `req` computes a fresh fee with inserted=0.
